// File: rtl/memce_sequencer_pkg.sv
// Shared types and helpers for the memory chip-enable sequencer.
package memce_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_CE0 = 2'd0,
    SEL_CE1 = 2'd1,
    SEL_CS  = 2'd2,
    SEL_BAD = 2'd3
  } sel_t;

  // Anything but a clean one-hot {memce0, memce1, cs}, X/Z included, lands in default.
  function automatic sel_t decode_sel(input logic [2:0] sel);
    sel_t res;
    case (sel)
      3'b100:  res = SEL_CE0;
      3'b010:  res = SEL_CE1;
      3'b001:  res = SEL_CS;
      default: res = SEL_BAD;
    endcase
    return res;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/memce_sequencer_if.sv
// Request, response and external memory bus of the sequencer.
interface memce_sequencer_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          memce0;
  logic          memce1;
  logic          cs;
  logic          mem_ce0_n;
  logic          mem_ce1_n;
  logic          mem_cs_n;
  logic          mem_oe_n;
  logic          mem_we_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, memce0, memce1, cs, mem_rdata, rsp_ready,
    input  req_ready, mem_ce0_n, mem_ce1_n, mem_cs_n, mem_oe_n, mem_we_n, mem_addr, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, memce0, memce1, cs, mem_rdata, rsp_ready,
    output req_ready, mem_ce0_n, mem_ce1_n, mem_cs_n, mem_oe_n, mem_we_n, mem_addr, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/memce_sequencer_wait_counter.sv
// Loadable down-counter timing the SETUP, STROBE and HOLD phases.
module memce_wait_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_r;

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - CW'(1'b1);
    end
  end

  assign done = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/memce_sequencer.sv
// Single-outstanding memory access sequencer driving wait-state-timed active-low strobes.
module memce_sequencer
  import memce_seq_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int SETUP  = 1,
  parameter int WAIT0  = 2,
  parameter int WAIT1  = 4,
  parameter int WAITCS = 1,
  parameter int HOLD   = 1
) (
  input logic              clk,
  input logic              rst_n,
  memce_sequencer_if.slave bus
);

  localparam int MAXT = max_of(max_of(max_of(SETUP, WAIT0), max_of(WAIT1, WAITCS)), HOLD);
  localparam int CW   = $clog2(MAXT + 1);

  // Counter reload values are phase length minus one so done marks the final cycle.
  localparam logic [CW-1:0] SETUP_LD = CW'((SETUP > 0) ? SETUP - 1 : 0);
  localparam logic [CW-1:0] HOLD_LD  = CW'((HOLD > 0) ? HOLD - 1 : 0);
  localparam logic [CW-1:0] W0_LD    = CW'(WAIT0 - 1);
  localparam logic [CW-1:0] W1_LD    = CW'(WAIT1 - 1);
  localparam logic [CW-1:0] WCS_LD   = CW'(WAITCS - 1);

  state_t        state_r, state_nxt_s;
  sel_t          sel_r;
  logic          we_r, chk_r, accept_s, strobe_s;
  logic          cnt_load_s, cnt_done_s;
  logic [CW-1:0] cnt_val_s;
  logic          req_ready_r, ce0_n_r, ce1_n_r, cs_n_r, oe_n_r, we_n_r;
  logic          rsp_valid_r, rsp_err_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r, rdata_r;

  memce_wait_counter #(.CW(CW)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .done     (cnt_done_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and counter reload; the cycle after acceptance stays in IDLE to judge the select.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    cnt_val_s   = {CW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (chk_r) begin
          if (sel_r == SEL_BAD) begin
            state_nxt_s = ST_RESP;
          end else if (SETUP > 0) begin
            state_nxt_s = ST_SETUP;
          end else begin
            state_nxt_s = ST_STROBE;
          end
        end else begin
          accept_s = bus.req_valid && req_ready_r;
        end
      end
      ST_SETUP: begin
        if (cnt_done_s) state_nxt_s = ST_STROBE;
        else            state_nxt_s = ST_SETUP;
      end
      ST_STROBE: begin
        if (cnt_done_s) state_nxt_s = (HOLD > 0) ? ST_HOLD : ST_RESP;
        else            state_nxt_s = ST_STROBE;
      end
      ST_HOLD: begin
        if (cnt_done_s) state_nxt_s = ST_RESP;
        else            state_nxt_s = ST_HOLD;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    case (state_nxt_s)
      ST_SETUP: cnt_val_s = SETUP_LD;
      ST_HOLD:  cnt_val_s = HOLD_LD;
      ST_STROBE: begin
        case (sel_r)
          SEL_CE1: cnt_val_s = W1_LD;
          SEL_CS:  cnt_val_s = WCS_LD;
          default: cnt_val_s = W0_LD;
        endcase
      end
      default: cnt_val_s = {CW{1'b0}};
    endcase
  end

  assign cnt_load_s = (state_nxt_s != state_r);
  assign strobe_s   = (state_nxt_s == ST_STROBE);

  // Registered control outputs decoded from the upcoming state, so strobes never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b0;
      ce0_n_r     <= 1'b1;
      ce1_n_r     <= 1'b1;
      cs_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE) && !accept_s;
      ce0_n_r     <= !(strobe_s && (sel_r == SEL_CE0));
      ce1_n_r     <= !(strobe_s && (sel_r == SEL_CE1));
      cs_n_r      <= !(strobe_s && (sel_r == SEL_CS));
      oe_n_r      <= !(strobe_s && !we_r);
      we_n_r      <= !(strobe_s && we_r);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      rsp_err_r   <= (state_nxt_s == ST_RESP) && (sel_r == SEL_BAD);
    end
  end

  // Request latches and read-data capture on the edge closing the last strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_r   <= 1'b0;
      we_r    <= 1'b0;
      sel_r   <= SEL_BAD;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
      rdata_r <= {DW{1'b0}};
    end else begin
      chk_r <= accept_s;
      if (accept_s) begin
        we_r    <= bus.req_we;
        sel_r   <= decode_sel({bus.memce0, bus.memce1, bus.cs});
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        rdata_r <= {DW{1'b0}};
      end else if ((state_r == ST_STROBE) && cnt_done_s && !we_r) begin
        rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.mem_ce0_n = ce0_n_r;
  assign bus.mem_ce1_n = ce1_n_r;
  assign bus.mem_cs_n  = cs_n_r;
  assign bus.mem_oe_n  = oe_n_r;
  assign bus.mem_we_n  = we_n_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule
